// File: rtl/furry_sequencer.sv
// furry_sequencer: buffers one frame of ADC samples, then feeds them to the
// furry spectral core one sample per end_flag request until the core finishes
// or the run times out. Reports frame completion and sticky error status.
module furry_sequencer #(
    parameter int DATA_W         = 16,
    parameter int NUM_SAMPLES    = 17,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic [DATA_W-1:0] core_signal,
    output logic              core_start,
    input  logic              core_finish,
    input  logic              core_end,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic              overrun,
    output logic              timeout_err,
    input  logic              clear_status,
    output logic              busy
);

    localparam int IDX_W = $clog2(NUM_SAMPLES);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SAMPLES - 1);
    localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_FILL = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state;
    logic [DATA_W-1:0] sbuf [NUM_SAMPLES];
    logic [IDX_W-1:0]  wr_ptr;
    logic [IDX_W-1:0]  rd_idx;
    logic              end_q;
    logic [TMR_W-1:0]  timer;
    logic              aborted;
    logic              req;
    logic              timed_out;
    logic              ovr_set;

    assign sample_ready = (state == S_FILL);
    assign busy         = (state != S_FILL);
    assign frame_done   = (state == S_DONE);
    // Only the rising edge of end_flag asks for the next sample.
    assign req          = core_end & ~end_q;
    // Finish wins over a timeout landing in the same cycle.
    assign timed_out    = (state == S_RUN) && !core_finish && (timer == LAST_TICK);
    // Anything offered while not filling is dropped and flagged.
    assign ovr_set      = sample_valid && !sample_ready;

    // Sample buffer: written only while filling, contents untouched otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SAMPLES; i++) sbuf[i] <= '0;
        end else if (state == S_FILL && sample_valid) begin
            sbuf[wr_ptr] <= sample_in;
        end
    end

    // Frame FSM: fill -> arm -> run -> done, plus the core handshake and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_FILL;
            wr_ptr      <= '0;
            rd_idx      <= '0;
            end_q       <= 1'b0;
            timer       <= '0;
            aborted     <= 1'b0;
            core_start  <= 1'b0;
            core_signal <= '0;
            frame_count <= '0;
        end else begin
            end_q <= core_end;
            case (state)
                S_FILL: begin
                    if (sample_valid) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (wr_ptr == LAST_IDX) state <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (enable) begin
                        core_start  <= 1'b1;
                        core_signal <= sbuf[0];
                        rd_idx      <= '0;
                        timer       <= '0;
                        aborted     <= 1'b0;
                        state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    // core_signal trails rd_idx by one cycle.
                    core_signal <= sbuf[rd_idx];
                    timer       <= timer + 1'b1;
                    if (core_finish) begin
                        core_start <= 1'b0;
                        state      <= S_DONE;
                    end else if (timer == LAST_TICK) begin
                        core_start <= 1'b0;
                        aborted    <= 1'b1;
                        state      <= S_DONE;
                    end else if (req && rd_idx != LAST_IDX) begin
                        // Requests past the last sample keep re-sending it.
                        rd_idx <= rd_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!aborted) frame_count <= frame_count + 16'd1;
                    wr_ptr     <= '0;
                    core_start <= 1'b0;
                    state      <= S_FILL;
                end
                default: state <= S_FILL;
            endcase
        end
    end

    // Sticky status flags; a set event beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (ovr_set)           overrun <= 1'b1;
            else if (clear_status) overrun <= 1'b0;
            if (timed_out)         timeout_err <= 1'b1;
            else if (clear_status) timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_furry_sequencer.sv
// Bench for furry_sequencer: directed frames on a default-timeout instance
// checked every cycle against a queue-based frame model, plus a 64-cycle
// timeout instance checked with directed expectations.
module tb_furry_sequencer;

    localparam int NS = 17;
    localparam int MT = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        core_finish = 1'b0;
    logic        core_end = 1'b0;
    logic        clear_status = 1'b0;
    logic        sample_ready, core_start, frame_done, overrun, timeout_err, busy;
    logic [15:0] core_signal, frame_count;

    logic        t_enable = 1'b0;
    logic [15:0] t_sample = '0;
    logic        t_valid = 1'b0;
    logic        t_zero = 1'b0;
    logic        t_ready, t_start, t_done, t_ovr, t_tmo, t_busy;
    logic [15:0] t_sig, t_count;

    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    int samples [NS] = '{5847, -2891, 21843, -17, 300, 32767, -32768, 1000, -1000,
                         12345, -12345, 7, 0, 4444, -9999, 15000, 8912};

    furry_sequencer dut (
        .clk(clk), .reset(reset), .enable(enable), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .core_signal(core_signal), .core_start(core_start),
        .core_finish(core_finish), .core_end(core_end), .frame_done(frame_done),
        .frame_count(frame_count), .overrun(overrun), .timeout_err(timeout_err),
        .clear_status(clear_status), .busy(busy)
    );

    furry_sequencer #(.TIMEOUT_CYCLES(64)) dut_t (
        .clk(clk), .reset(reset), .enable(t_enable), .sample_in(t_sample),
        .sample_valid(t_valid), .sample_ready(t_ready),
        .core_signal(t_sig), .core_start(t_start),
        .core_finish(t_zero), .core_end(t_zero), .frame_done(t_done),
        .frame_count(t_count), .overrun(t_ovr), .timeout_err(t_tmo),
        .clear_status(t_zero), .busy(t_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int val(input int i, input int rot);
        return samples[(i + rot) % NS];
    endfunction

    function automatic int sig();
        return int'($signed(core_signal));
    endfunction

    // ---------------- frame model ----------------
    int  m_mode;   // 0 filling, 1 armed, 2 running, 3 done
    int  m_q[$];
    int  m_idx, m_timer, m_sig, m_cnt;
    bit  m_start, m_prev_end, m_ovr, m_tmo, m_abort;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_mode = 0; m_q.delete(); m_idx = 0; m_timer = 0; m_sig = 0; m_cnt = 0;
            m_start = 0; m_prev_end = 0; m_ovr = 0; m_tmo = 0; m_abort = 0;
        end else begin
            if (sample_valid && m_mode != 0) m_ovr = 1;
            else if (clear_status) m_ovr = 0;
            if (clear_status) m_tmo = 0;
            case (m_mode)
                0: if (sample_valid) begin
                    m_q.push_back(int'($signed(sample_in)));
                    if (m_q.size() == NS) m_mode = 1;
                end
                1: if (enable) begin
                    m_start = 1; m_sig = m_q[0]; m_idx = 0; m_timer = 0; m_mode = 2;
                end
                2: begin
                    m_sig = m_q[m_idx];
                    if (core_finish) begin
                        m_start = 0; m_abort = 0; m_mode = 3;
                    end else if (m_timer == MT - 1) begin
                        m_start = 0; m_abort = 1; m_tmo = 1; m_mode = 3;
                    end else if (core_end && !m_prev_end && m_idx < NS - 1) begin
                        m_idx++;
                    end
                    m_timer++;
                end
                default: begin
                    if (!m_abort) m_cnt = (m_cnt + 1) % 65536;
                    m_q.delete();
                    m_mode = 0;
                end
            endcase
            m_prev_end = core_end;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("ready",       sample_ready, int'(m_mode == 0));
            chk("busy",        busy,         int'(m_mode != 0));
            chk("frame_done",  frame_done,   int'(m_mode == 3));
            chk("core_start",  core_start,   m_start);
            chk("core_signal", sig(),        m_sig);
            chk("frame_count", frame_count,  m_cnt);
            chk("overrun",     overrun,      m_ovr);
            chk("timeout_err", timeout_err,  m_tmo);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic load(input int rot);
        for (int i = 0; i < NS; i++) begin
            sample_valid = 1'b1;
            sample_in = 16'(val(i, rot));
            tick();
        end
        sample_valid = 1'b0;
    endtask

    task automatic pulse_end();
        core_end = 1'b1; tick(); core_end = 1'b0; tick(19);
    endtask

    task automatic run_frame(input int rot, input int npulse, input int inject_at, input int exp_cnt);
        load(rot);
        chk("arm_no_start", core_start, 0);
        chk("arm_busy", busy, 1);
        tick();
        chk("start_rise", core_start, 1);
        chk("first_sig", sig(), val(0, rot));
        for (int p = 1; p <= npulse; p++) begin
            if (p == inject_at) begin
                sample_valid = 1'b1; sample_in = 16'd1234; tick(); sample_valid = 1'b0;
                chk("ovr_set", overrun, 1);
            end
            pulse_end();
            chk("seq_sig", sig(), val(p < NS - 1 ? p : NS - 1, rot));
        end
        core_finish = 1'b1; tick(); core_finish = 1'b0;
        chk("fin_start_low", core_start, 0);
        chk("fin_done", frame_done, 1);
        tick();
        chk("fin_count", frame_count, exp_cnt);
        chk("fin_ready", sample_ready, 1);
    endtask

    initial begin
        int n;
        // reset
        tick(3);
        chk("rst_start", core_start, 0);
        chk("rst_sig", sig(), 0);
        chk("rst_count", frame_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk_en = 1;
        reset = 1'b1;
        enable = 1'b1;
        tick();
        chk("rel_ready", sample_ready, 1);

        // frame 1: 17 samples, requests every 20 cycles, then finish
        run_frame(0, 16, 0, 1);
        chk("last_8912", sig(), 8912);

        // frame 2: 20 requests saturate on last sample, plus a dropped sample
        run_frame(0, 20, 3, 2);
        chk("ovr_sticky", overrun, 1);

        // frame 3: first sample after DONE lands in slot 0; finish+request together
        load(2);
        chk("ovr_hold", overrun, 1);
        tick();
        chk("buf0_not_1234", sig(), 21843);
        clear_status = 1'b1; tick(); clear_status = 1'b0;
        chk("ovr_clr", overrun, 0);
        for (int p = 0; p < 4; p++) pulse_end();
        chk("sample5", sig(), val(4, 2));
        core_end = 1'b1; core_finish = 1'b1; tick(); core_end = 1'b0; core_finish = 1'b0;
        chk("fr_start_low", core_start, 0);
        chk("fr_done", frame_done, 1);
        chk("fr_sig_hold", sig(), val(4, 2));
        tick();
        chk("fr_ready", sample_ready, 1);
        chk("fr_count", frame_count, 3);

        // frame 4: async reset in the middle of the run
        load(3);
        tick();
        for (int p = 0; p < 8; p++) pulse_end();
        chk("pre_rst_sig", sig(), val(8, 3));
        #2 reset = 1'b0;
        #1;
        chk("arst_start", core_start, 0);
        chk("arst_sig", sig(), 0);
        chk("arst_count", frame_count, 0);
        chk("arst_busy", busy, 0);
        tick(2);
        reset = 1'b1;
        tick();
        chk("post_rst_ready", sample_ready, 1);
        chk("post_rst_busy", busy, 0);

        // frame 5: full frame after reset
        run_frame(0, 16, 0, 1);

        // timeout instance: never finishes, aborts after 64 run cycles
        t_enable = 1'b1;
        for (int i = 0; i < NS; i++) begin
            t_valid = 1'b1; t_sample = 16'(val(i, 0)); tick();
        end
        t_valid = 1'b0;
        n = 0;
        while (!t_start && n < 10) begin tick(); n++; end
        chk("to_start_seen", t_start, 1);
        chk("to_first_sig", int'($signed(t_sig)), 5847);
        n = 0;
        while (t_start && n < 200) begin n++; tick(); end
        chk("to_run_cycles", n, 64);
        chk("to_err", t_tmo, 1);
        chk("to_done", t_done, 1);
        tick();
        chk("to_count", t_count, 0);
        chk("to_ready", t_ready, 1);
        chk("to_err_sticky", t_tmo, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
